// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// The signature output is built only when ALU_SEQ_SIGNATURE_EN is defined.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StSettle  = 2'd1,
      StPresent = 2'd2,
      StFinish  = 2'd3
   } seq_state_e;

   localparam int unsigned DefWidth = 4;
   localparam int unsigned DefOpw   = 4;
   localparam int unsigned SIG_W    = 16;

   function automatic logic [SIG_W-1:0] sig_rotl(input logic [SIG_W-1:0] s);
      return {s[SIG_W-2:0], s[SIG_W-1]};
   endfunction

endpackage

// File: rtl/alu_seq_counter.sv
// Mixed-radix {a, b, op} sweep counter: op is the fastest digit, a the slowest.
module alu_seq_counter
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned OPW   = DefOpw
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             advance_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [OPW-1:0]   op_o,
   output logic             last_o
);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [OPW-1:0]   op_q, op_d;

   always_comb begin
      a_d  = a_q;
      b_d  = b_q;
      op_d = op_q;
      if (clear_i) begin
         a_d  = '0;
         b_d  = '0;
         op_d = '0;
      end else if (advance_i) begin
         op_d = op_q + 1'b1;
         // Each digit wraps all-ones -> 0 and carries into the next one.
         if (&op_q) begin
            b_d = b_q + 1'b1;
            if (&b_q) begin
               a_d = a_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= '0;
      end else begin
         a_q  <= a_d;
         b_q  <= b_d;
         op_q <= op_d;
      end
   end

   assign a_o    = a_q;
   assign b_o    = b_q;
   assign op_o   = op_q;
   assign last_o = (&a_q) & (&b_q) & (&op_q);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sweeps every {a, b, op} vector through an external ALU and presents each captured
// result on a valid/ready port. Define ALU_SEQ_SIGNATURE_EN to add the 16-bit `sig` output.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH   = DefWidth,
   parameter int unsigned OPW     = DefOpw,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_x,
   input  logic [WIDTH-1:0] alu_y,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_a,
   output logic [WIDTH-1:0] res_b,
   output logic [OPW-1:0]   res_op,
   output logic [WIDTH-1:0] res_x,
   output logic [WIDTH-1:0] res_y,
   output logic             busy,
`ifdef ALU_SEQ_SIGNATURE_EN
   output logic [SIG_W-1:0] sig,
`endif
   output logic             done
);

   localparam int unsigned SettleW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

   seq_state_e       state_q, state_d;
   logic [SettleW-1:0] settle_q, settle_d;
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_a_q, res_a_d;
   logic [WIDTH-1:0] res_b_q, res_b_d;
   logic [OPW-1:0]   res_op_q, res_op_d;
   logic [WIDTH-1:0] res_x_q, res_x_d;
   logic [WIDTH-1:0] res_y_q, res_y_d;

   logic cnt_clear, cnt_advance, cnt_last;
   logic handshake;

   alu_seq_counter #(
      .WIDTH (WIDTH),
      .OPW   (OPW)
   ) u_counter (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .clear_i   (cnt_clear),
      .advance_i (cnt_advance),
      .a_o       (alu_a),
      .b_o       (alu_b),
      .op_o      (alu_op),
      .last_o    (cnt_last)
   );

   assign handshake = res_valid_q & res_ready;

   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      res_valid_d = res_valid_q;
      res_a_d     = res_a_q;
      res_b_d     = res_b_q;
      res_op_d    = res_op_q;
      res_x_d     = res_x_q;
      res_y_d     = res_y_q;
      cnt_clear   = 1'b0;
      cnt_advance = 1'b0;

      if (abort && (state_q != StIdle)) begin
         // Abort outranks capture and handshake; the operand counter simply holds.
         state_d     = StIdle;
         settle_d    = '0;
         res_valid_d = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start && !abort) begin
                  state_d   = StSettle;
                  settle_d  = '0;
                  cnt_clear = 1'b1;
               end
            end
            StSettle: begin
               if (settle_q == SettleW'(ALU_LAT)) begin
                  res_a_d     = alu_a;
                  res_b_d     = alu_b;
                  res_op_d    = alu_op;
                  res_x_d     = alu_x;
                  res_y_d     = alu_y;
                  res_valid_d = 1'b1;
                  settle_d    = '0;
                  state_d     = StPresent;
               end else begin
                  settle_d = settle_q + 1'b1;
               end
            end
            StPresent: begin
               if (handshake) begin
                  res_valid_d = 1'b0;
                  if (cnt_last) begin
                     state_d = StFinish;
                  end else begin
                     cnt_advance = 1'b1;
                     state_d     = StSettle;
                  end
               end
            end
            StFinish: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         settle_q    <= '0;
         res_valid_q <= 1'b0;
         res_a_q     <= '0;
         res_b_q     <= '0;
         res_op_q    <= '0;
         res_x_q     <= '0;
         res_y_q     <= '0;
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         res_valid_q <= res_valid_d;
         res_a_q     <= res_a_d;
         res_b_q     <= res_b_d;
         res_op_q    <= res_op_d;
         res_x_q     <= res_x_d;
         res_y_q     <= res_y_d;
      end
   end

`ifdef ALU_SEQ_SIGNATURE_EN
   logic [SIG_W-1:0] sig_q, sig_d;
   logic [SIG_W-1:0] sig_mix;

   always_comb begin
      // {res_x, res_y} zero-extended into the signature width.
      sig_mix = SIG_W'({res_x_q, res_y_q});
      sig_d   = sig_q;
      if (cnt_clear) begin
         sig_d = '0;
      end else if ((state_q == StPresent) && handshake && !abort) begin
         sig_d = sig_rotl(sig_q) ^ sig_mix;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;
`endif

   assign res_valid = res_valid_q;
   assign res_a     = res_a_q;
   assign res_b     = res_b_q;
   assign res_op    = res_op_q;
   assign res_x     = res_x_q;
   assign res_y     = res_y_q;
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StFinish);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a 2-cycle model ALU (x=a+b, y=a^b) and a
// scoreboard of expected vectors; checks `sig` too when ALU_SEQ_SIGNATURE_EN is defined.
module tb_alu_op_sequencer;

   localparam int LAT   = 2;
   localparam int NVEC  = 4096;
   localparam int BUDGET = NVEC * (LAT + 2) + 200;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [3:0] alu_a, alu_b, alu_op, alu_x, alu_y;
   logic       res_valid, res_ready;
   logic [3:0] res_a, res_b, res_op, res_x, res_y;
   logic       busy, done;
`ifdef ALU_SEQ_SIGNATURE_EN
   logic [15:0] sig;
`endif

   alu_op_sequencer #(
      .WIDTH   (4),
      .OPW     (4),
      .ALU_LAT (LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_x     (alu_x),
      .alu_y     (alu_y),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_a     (res_a),
      .res_b     (res_b),
      .res_op    (res_op),
      .res_x     (res_x),
      .res_y     (res_y),
      .busy      (busy),
`ifdef ALU_SEQ_SIGNATURE_EN
      .sig       (sig),
`endif
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model ALU with LAT register stages.
   logic [7:0] pipe [LAT];
   always_ff @(posedge clk) begin
      pipe[0] <= {alu_a + alu_b, alu_a ^ alu_b};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign {alu_x, alu_y} = pipe[LAT-1];

   logic [31:0] q [$];
   logic [15:0] exp_sig;
   int n, hs_cnt, done_cnt, done_n, n_valid, stall_left;
   int valid_n [2];
   logic prev_valid;
   logic [11:0] stall_vec;
   int n_pass, n_total;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] obs_pack();
      return {res_a, res_b, res_op, res_x, res_y, alu_a, alu_b, alu_op};
   endfunction

   // One clock: drive ready, score a pending handshake, advance, record done.
   task automatic cycle();
      logic [31:0] exp_v;
      if (res_valid && stall_left > 0 && {res_a, res_b, res_op} == stall_vec) begin
         res_ready = 1'b0;
         stall_left--;
         if (q.size() > 0) chk("stall_hold", obs_pack(), q[0]);
         else chk("stall_sb_empty", 1, 0);
      end else begin
         res_ready = 1'b1;
      end
      if (res_valid && res_ready) begin
         if (q.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            exp_v = q.pop_front();
            chk("vector", obs_pack(), exp_v);
            exp_sig = {exp_sig[14:0], exp_sig[15]} ^ {8'h00, exp_v[19:12]};
         end
         hs_cnt++;
      end
      if (res_valid && !prev_valid && n_valid < 2) begin
         valid_n[n_valid] = n;
         n_valid++;
      end
      prev_valid = res_valid;
      @(posedge clk);
      #1;
      n++;
      if (done) begin
         done_cnt++;
         done_n = n;
      end
   endtask

   task automatic start_sweep();
      logic [11:0] vv;
      logic [3:0]  ea, eb, eo, ex, ey;
      q.delete();
      for (int v = 0; v < NVEC; v++) begin
         vv = 12'(v);
         ea = vv[11:8];
         eb = vv[7:4];
         eo = vv[3:0];
         ex = ea + eb;
         ey = ea ^ eb;
         q.push_back({ea, eb, eo, ex, ey, ea, eb, eo});
      end
      exp_sig    = '0;
      hs_cnt     = 0;
      done_cnt   = 0;
      n_valid    = 0;
      prev_valid = 1'b0;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n     = 0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
      n_pass = 0; n_total = 0; stall_left = 0; stall_vec = '0;
      n = 0; hs_cnt = 0; done_cnt = 0; done_n = 0; n_valid = 0; prev_valid = 1'b0;
      exp_sig = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {res_valid, busy, done, obs_pack()}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_after_reset", {busy, done, res_valid}, 0);

      // Full sweep, consumer always ready.
      start_sweep();
      chk("busy_after_start", busy, 1);
      while (done_cnt == 0 && n < BUDGET) cycle();
      chk("first_valid_cycle", valid_n[0], LAT + 1);
      chk("second_valid_cycle", valid_n[1], 2 * LAT + 3);
      chk("done_cycle", done_n, NVEC * (LAT + 2));
      chk("handshakes", hs_cnt, NVEC);
      chk("alu_hold_after_done", {alu_a, alu_b, alu_op}, 12'hfff);
      cycle();
      chk("done_one_cycle", {done, busy}, 0);
      chk("done_count", done_cnt, 1);
      chk("sb_drained", q.size(), 0);
`ifdef ALU_SEQ_SIGNATURE_EN
      chk("sig_final", sig, exp_sig);
`endif

      // Abort during SETTLE of vector 100.
      start_sweep();
`ifdef ALU_SEQ_SIGNATURE_EN
      chk("sig_clear_on_start", sig, 0);
`endif
      while (hs_cnt < 100 && n < BUDGET) cycle();
      chk("settle_vec100", {busy, res_valid, alu_a, alu_b, alu_op}, {2'b10, 12'h064});
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_idle", {busy, res_valid, done}, 0);
      chk("abort_alu_hold", {alu_a, alu_b, alu_op}, 12'h064);
      repeat (5) cycle();
      chk("no_done_after_abort", done_cnt, 0);
`ifdef ALU_SEQ_SIGNATURE_EN
      chk("sig_frozen", sig, exp_sig);
`endif
      q.delete();

      // start together with abort in IDLE is ignored.
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_idle", busy, 0);

      // Restart, ignored mid-sweep start, 5-cycle stall on a=3,b=7,op=2.
      stall_vec  = 12'h372;
      stall_left = 5;
      start_sweep();
      chk("restart_at_zero", {alu_a, alu_b, alu_op}, 0);
      while (hs_cnt < 50 && n < BUDGET) cycle();
      start = 1'b1;
      cycle();
      start = 1'b0;
      while (hs_cnt < 883 && n < BUDGET) cycle();
      chk("stall_cycles_used", stall_left, 0);
      chk("after_stall_vec", {alu_a, alu_b, alu_op}, 12'h373);
      while (!res_valid && n < BUDGET) cycle();
      chk("present_vec883", {res_valid, res_a, res_b, res_op}, {1'b1, 12'h373});

      // Asynchronous reset mid-PRESENT.
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {res_valid, busy, done, obs_pack()}, 0);
`ifdef ALU_SEQ_SIGNATURE_EN
      chk("async_reset_sig", sig, 0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q.delete();
      done_cnt = 0;
      repeat (3) cycle();
      chk("idle_after_async_reset", {busy, res_valid, done}, 0);
      chk("no_done_after_reset", done_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
